// File: rtl/vm_param_vend_pkg.sv
// Shared types and helpers for the parametrised vending core.
package vm_param_vend_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        AVAILABLE    = 2'd1,
        OUT_OF_STOCK = 2'd2,
        ERROR        = 2'd3
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SUPPLY,
        S_CHECK,
        S_COLLECT,
        S_VEND,
        S_REFUND
    } state_t;

    // Add clamped to max; callers narrow the result back to their field width.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[31:0];
    endfunction

endpackage

// File: rtl/vm_txn_timer.sv
// Selection idle timer: counts while run, restarts on clear, flags the last cycle.
module vm_txn_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic hrst_n,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!hrst_n || clear)
            cnt <= '0;
        else if (run && cnt != LAST)
            cnt <= cnt + 1'b1;
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/vm_param_vend_core.sv
// Vending controller core: supplier restock/pricing and user coin-by-coin purchase.
module vm_param_vend_core
    import vm_param_vend_pkg::*;
#(
    parameter int NUM_ITEMS   = 8,
    parameter int ITEM_W      = $clog2(NUM_ITEMS),
    parameter int COUNT_W     = 4,
    parameter int COST_W      = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              hrst_n,
    input  logic              srst,
    input  logic              valid,
    input  logic [ITEM_W-1:0] item,
    input  logic [COUNT_W-1:0] count,
    input  logic [COST_W-1:0] cost,
    input  logic [ITEM_W-1:0] buttons,
    input  logic              select,
    input  logic              coin_valid,
    input  logic [COST_W-1:0] coin_value,
    output logic [1:0]        status,
    output logic              insert_coins,
    output logic              start_timer,
    output logic              timeout,
    output logic              insufficient_amount,
    output logic              dispense,
    output logic [ITEM_W-1:0] dispense_item,
    output logic              change_valid,
    output logic [COST_W-1:0] change,
    output logic [COST_W-1:0] credit
);

    localparam logic [31:0] COUNT_MAX = (32'd1 << COUNT_W) - 32'd1;
    localparam logic [31:0] COST_MAX  = (32'd1 << COST_W) - 32'd1;

    logic [COUNT_W-1:0] stock [NUM_ITEMS];
    logic [COST_W-1:0]  price [NUM_ITEMS];

    state_t             state, state_d;
    status_t            status_q, status_d;
    logic [ITEM_W-1:0]  sel, sel_d;
    logic [COST_W-1:0]  credit_d, cred_sum;
    logic [COUNT_W-1:0] stock_sum;
    logic               paid, expire;
    logic               insert_d, timeout_d, insuff_d, dispense_d, change_valid_d;
    logic [ITEM_W-1:0]  dispense_item_d;
    logic [COST_W-1:0]  change_d;

    // A coin in the collect cycle restarts the idle window.
    vm_txn_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .hrst_n (hrst_n),
        .clear  ((state != S_COLLECT) || coin_valid),
        .run    (state == S_COLLECT),
        .expire (expire)
    );

    always_comb begin
        stock_sum = COUNT_W'(sat_add(32'(stock[item]), 32'(count), COUNT_MAX));
        cred_sum  = coin_valid ? COST_W'(sat_add(32'(credit), 32'(coin_value), COST_MAX))
                               : credit;
        paid      = (cred_sum >= price[sel]);
    end

    always_comb begin
        state_d         = state;
        status_d        = status_q;
        sel_d           = sel;
        credit_d        = credit;
        timeout_d       = 1'b0;
        insuff_d        = 1'b0;
        dispense_d      = 1'b0;
        dispense_item_d = '0;
        change_valid_d  = 1'b0;
        change_d        = '0;
        case (state)
            S_IDLE: begin
                if (valid)
                    state_d = S_SUPPLY;
                else if (buttons != '0) begin
                    sel_d   = buttons;
                    state_d = S_CHECK;
                end
            end
            S_SUPPLY: begin
                // ERROR flags only the offending cycle, then falls back to IDLE.
                if (valid && item == '0)
                    status_d = ERROR;
                else if (status_q == ERROR)
                    status_d = IDLE;
                if (!valid)
                    state_d = S_IDLE;
            end
            S_CHECK: begin
                if (srst)
                    state_d = S_REFUND;
                else if (stock[sel] != '0 && price[sel] != '0) begin
                    status_d = AVAILABLE;
                    state_d  = S_COLLECT;
                end else begin
                    status_d = OUT_OF_STOCK;
                    state_d  = S_IDLE;
                end
            end
            S_COLLECT: begin
                credit_d = cred_sum;
                if (srst)
                    state_d = S_REFUND;
                else if (select && paid)
                    state_d = S_VEND;
                else begin
                    insuff_d = select;
                    if (!coin_valid && expire) begin
                        timeout_d = 1'b1;
                        state_d   = S_REFUND;
                    end
                end
            end
            S_VEND: begin
                dispense_d      = 1'b1;
                dispense_item_d = sel;
                change_d        = credit - price[sel];
                change_valid_d  = (change_d != '0);
                credit_d        = '0;
                state_d         = S_IDLE;
            end
            S_REFUND: begin
                change_d       = credit;
                change_valid_d = (credit != '0);
                credit_d       = '0;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        insert_d = (state_d == S_COLLECT);
    end

    always_ff @(posedge clk) begin
        if (!hrst_n) begin
            state               <= S_IDLE;
            status_q            <= IDLE;
            sel                 <= '0;
            credit              <= '0;
            insert_coins        <= 1'b0;
            start_timer         <= 1'b0;
            timeout             <= 1'b0;
            insufficient_amount <= 1'b0;
            dispense            <= 1'b0;
            dispense_item       <= '0;
            change_valid        <= 1'b0;
            change              <= '0;
        end else begin
            state               <= state_d;
            status_q            <= status_d;
            sel                 <= sel_d;
            credit              <= credit_d;
            insert_coins        <= insert_d;
            start_timer         <= insert_d;
            timeout             <= timeout_d;
            insufficient_amount <= insuff_d;
            dispense            <= dispense_d;
            dispense_item       <= dispense_item_d;
            change_valid        <= change_valid_d;
            change              <= change_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!hrst_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock[i] <= '0;
                price[i] <= '0;
            end
        end else begin
            if (state == S_SUPPLY && valid && item != '0) begin
                stock[item] <= stock_sum;
                price[item] <= cost;
            end
            if (state == S_VEND)
                stock[sel] <= stock[sel] - 1'b1;
        end
    end

    assign status = status_q;

endmodule

// File: tb/tb_vm_param_vend_core.sv
// Directed bench for vm_param_vend_core with hand-computed expectations.
module tb_vm_param_vend_core;

    localparam int NUM_ITEMS = 8;
    localparam int ITEM_W    = 3;
    localparam int COUNT_W   = 4;
    localparam int COST_W    = 8;
    localparam int TO        = 64;

    logic              clk = 1'b0;
    logic              hrst_n, srst, valid, select, coin_valid;
    logic [ITEM_W-1:0] item, buttons;
    logic [COUNT_W-1:0] count;
    logic [COST_W-1:0] cost, coin_value;
    logic [1:0]        status;
    logic              insert_coins, start_timer, timeout, insufficient_amount;
    logic              dispense, change_valid;
    logic [ITEM_W-1:0] dispense_item;
    logic [COST_W-1:0] change, credit;

    int n_checks = 0;
    int n_errors = 0;

    vm_param_vend_core #(
        .NUM_ITEMS(NUM_ITEMS), .COUNT_W(COUNT_W), .COST_W(COST_W), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .hrst_n(hrst_n), .srst(srst), .valid(valid), .item(item),
        .count(count), .cost(cost), .buttons(buttons), .select(select),
        .coin_valid(coin_valid), .coin_value(coin_value), .status(status),
        .insert_coins(insert_coins), .start_timer(start_timer), .timeout(timeout),
        .insufficient_amount(insufficient_amount), .dispense(dispense),
        .dispense_item(dispense_item), .change_valid(change_valid),
        .change(change), .credit(credit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic supply(input int it, input int cnt, input int cst);
        valid = 1'b1; item = '0; tick();
        item = ITEM_W'(it); count = COUNT_W'(cnt); cost = COST_W'(cst); tick();
        valid = 1'b0; item = '0; count = '0; cost = '0; tick();
    endtask

    // Leaves the core in its first collect cycle (or idle if unavailable).
    task automatic buy(input int it);
        buttons = ITEM_W'(it); tick();
        buttons = '0; tick();
    endtask

    task automatic coin(input int v);
        coin_valid = 1'b1; coin_value = COST_W'(v); tick();
        coin_valid = 1'b0; coin_value = '0;
    endtask

    initial begin
        logic seen_to;
        hrst_n = 1'b0; srst = 1'b0; valid = 1'b0; select = 1'b0; coin_valid = 1'b0;
        item = '0; buttons = '0; count = '0; cost = '0; coin_value = '0;
        tick(); tick();
        chk("rst_status", status, 0);
        chk("rst_insert", insert_coins, 0);
        chk("rst_dispense", dispense, 0);
        chk("rst_credit", credit, 0);
        hrst_n = 1'b1; tick();

        // exact payment, no change
        supply(3, 5, 20);
        chk("stock3_init", dut.stock[3], 5);
        buy(3);
        chk("avail_status", status, 1);
        chk("avail_insert", insert_coins, 1);
        chk("avail_timer", start_timer, 1);
        coin(10); coin(10);
        chk("credit20", credit, 20);
        select = 1'b1; tick(); select = 1'b0; tick();
        chk("v1_dispense", dispense, 1);
        chk("v1_item", dispense_item, 3);
        chk("v1_cv", change_valid, 0);
        chk("v1_stock", dut.stock[3], 4);
        tick();
        chk("v1_pulse_end", dispense, 0);

        // same-cycle coin and select, change returned
        supply(2, 1, 15);
        buy(2);
        coin_valid = 1'b1; coin_value = 8'd25; select = 1'b1; tick();
        coin_valid = 1'b0; coin_value = '0; select = 1'b0; tick();
        chk("v2_dispense", dispense, 1);
        chk("v2_cv", change_valid, 1);
        chk("v2_change", change, 10);
        chk("v2_credit", credit, 0);

        // insufficient credit then top-up
        supply(4, 2, 30);
        buy(4);
        coin(20);
        select = 1'b1; tick(); select = 1'b0;
        chk("ins_pulse", insufficient_amount, 1);
        chk("ins_collect", insert_coins, 1);
        tick();
        chk("ins_pulse_end", insufficient_amount, 0);
        coin(10);
        select = 1'b1; tick(); select = 1'b0; tick();
        chk("v3_dispense", dispense, 1);
        chk("v3_item", dispense_item, 4);
        chk("v3_cv", change_valid, 0);

        // timeout with a restarting coin mid-wait
        buy(4);
        coin(5);
        repeat (30) tick();
        coin(5);
        seen_to = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            if (timeout) seen_to = 1'b1;
        end
        chk("to_early", seen_to, 0);
        tick();
        chk("to_pulse", timeout, 1);
        chk("to_insert", insert_coins, 0);
        tick();
        chk("to_cv", change_valid, 1);
        chk("to_change", change, 10);
        chk("to_pulse_end", timeout, 0);

        // saturation and item 0 error
        supply(5, 14, 10);
        supply(5, 5, 10);
        chk("sat_stock", dut.stock[5], 15);
        valid = 1'b1; tick();
        item = '0; count = 4'd3; cost = 8'd9; tick();
        chk("err_status", status, 3);
        valid = 1'b0; count = '0; cost = '0; tick();
        chk("err_clear", status, 0);
        chk("err_nowrite", dut.stock[0], 0);

        // soft reset beats select
        supply(6, 1, 30);
        buy(6);
        coin(40);
        srst = 1'b1; select = 1'b1; tick();
        srst = 1'b0; select = 1'b0;
        chk("srst_nodisp0", dispense, 0);
        tick();
        chk("srst_cv", change_valid, 1);
        chk("srst_change", change, 40);
        chk("srst_nodisp1", dispense, 0);
        chk("srst_stock", dut.stock[6], 1);

        // hard reset mid-collect
        buy(6);
        coin(20);
        hrst_n = 1'b0; tick();
        chk("hrst_credit", credit, 0);
        chk("hrst_insert", insert_coins, 0);
        chk("hrst_status", status, 0);
        chk("hrst_cv", change_valid, 0);
        hrst_n = 1'b1; tick();
        chk("hrst_cv_after", change_valid, 0);
        chk("hrst_stock", dut.stock[6], 0);
        buy(6);
        chk("oos_status", status, 2);
        chk("oos_insert", insert_coins, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
